// File: rtl/dmio_pkg.sv
// dmio_pkg: shared constants and types for the dmio data memory.
// Holds the default address map, the data/I/O widths and the address decode enum.
// The top-level parameters take their defaults from the address map constants here.
package dmio_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned IO_W   = 8;

  localparam logic [63:0] DMIO_LED_ADDR = 64'h1000;
  localparam logic [63:0] DMIO_SW_ADDR  = 64'h1008;

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_LED  = 2'd1,
    SEL_SW   = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

endpackage

// File: rtl/dmio_ram.sv
// dmio_ram: DEPTH x 64-bit word array, async clear, synchronous write, combinational read.
// Ports: clk, rst_n, we_i (write enable), idx_i (word index), wdat_i (write data), rdat_o (read data).
// Read latency 0 cycles; write visible right after the write edge; no backpressure.
module dmio_ram
  import dmio_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdat_i,
  output logic [WORD_W-1:0] rdat_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdat_i;
    end
  end

  // No write-to-read bypass: a read of the word being written shows the old value until the edge.
  assign rdat_o = mem_q[idx_i];

endmodule

// File: rtl/dmio.sv
// dmio: data memory with memory-mapped LED output register and switch input port.
// Ports: clk, rst_n, direccion (byte address), dataWrite, sw, memWr in; lecturaLED, dataRead out.
// Loads combinational (0 cycles), stores on rising clk, no backpressure.
// Optional macro DMIO_SW_SYNC_EN: sw goes through a 2-flop synchronizer (2-edge read latency).
module dmio #(
  parameter int unsigned DEPTH    = 32,
  parameter logic [63:0] LED_ADDR = dmio_pkg::DMIO_LED_ADDR,
  parameter logic [63:0] SW_ADDR  = dmio_pkg::DMIO_SW_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] direccion,
  input  logic [63:0] dataWrite,
  input  logic [7:0]  sw,
  input  logic        memWr,
  output logic [7:0]  lecturaLED,
  output logic [63:0] dataRead
);

  import dmio_pkg::*;

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [63:0] RAM_BYTES = 64'(DEPTH) << 3;

  sel_t              sel;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdat;
  logic [IO_W-1:0]   led_q;
  logic [IO_W-1:0]   led_d;
  logic [IO_W-1:0]   sw_val;

  // Exact full-width compares; the I/O addresses win if they ever overlap the RAM window.
  always_comb begin
    sel = SEL_NONE;
    if (direccion == LED_ADDR) begin
      sel = SEL_LED;
    end else if (direccion == SW_ADDR) begin
      sel = SEL_SW;
    end else if (direccion < RAM_BYTES) begin
      sel = SEL_RAM;
    end
  end

  assign ram_we = memWr && (sel == SEL_RAM);

  // Bits [2:0] are dropped, so a misaligned address hits its containing word.
  dmio_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ram_we),
    .idx_i  (direccion[AW+2:3]),
    .wdat_i (dataWrite),
    .rdat_o (ram_rdat)
  );

  // Only the low byte of a store lands in the LED register.
  always_comb begin
    led_d = led_q;
    if (memWr && (sel == SEL_LED)) begin
      led_d = dataWrite[IO_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign lecturaLED = led_q;

`ifdef DMIO_SW_SYNC_EN
  logic [IO_W-1:0] sw_meta_q;
  logic [IO_W-1:0] sw_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_val = sw_sync_q;
`else
  assign sw_val = sw;
`endif

  always_comb begin
    dataRead = '0;
    case (sel)
      SEL_RAM:  dataRead = ram_rdat;
      SEL_LED:  dataRead = {{(WORD_W-IO_W){1'b0}}, led_q};
      SEL_SW:   dataRead = {{(WORD_W-IO_W){1'b0}}, sw_val};
      default:  dataRead = '0;
    endcase
  end

endmodule

// File: tb/tb_dmio.sv
module tb_dmio;

  logic        clk;
  logic        rst_n;
  logic [63:0] direccion;
  logic [63:0] dataWrite;
  logic [7:0]  sw;
  logic        memWr;
  logic [7:0]  lecturaLED;
  logic [63:0] dataRead;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];

  dmio #(
    .DEPTH    (32),
    .LED_ADDR (64'h1000),
    .SW_ADDR  (64'h1008)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .direccion  (direccion),
    .dataWrite  (dataWrite),
    .sw         (sw),
    .memWr      (memWr),
    .lecturaLED (lecturaLED),
    .dataRead   (dataRead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] expv;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [63:0] addr, input logic [63:0] expv);
    direccion = addr;
    memWr     = 1'b0;
    exp_q.push_back(expv);
    #1;
    chk(tag, dataRead);
  endtask

  task automatic led(input string tag, input logic [7:0] expv);
    exp_q.push_back({56'h0, expv});
    #1;
    chk(tag, {56'h0, lecturaLED});
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    direccion = addr;
    dataWrite = data;
    memWr     = 1'b1;
    @(posedge clk);
    #1;
    memWr = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    direccion = '0;
    dataWrite = '0;
    sw        = '0;
    memWr     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    led("rst_led", 8'h00);
    rd("rst_rd0", 64'h0, 64'h0);
    rd("rst_rd8", 64'h8, 64'h0);
    rd("rst_rdled", 64'h1000, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LED register
    wr(64'h1000, 64'hA);
    led("led_0a", 8'h0A);
    rd("led_rd_0a", 64'h1000, 64'h0A);
    wr(64'h1000, 64'hFFFF_FFFF_FFFF_FF5A);
    led("led_5a", 8'h5A);
    rd("led_rd_5a", 64'h1000, 64'h5A);

    // RAM, including misaligned access
    wr(64'h10, 64'hDEADBEEF_01234567);
    wr(64'h18, 64'h1);
    rd("ram_10", 64'h10, 64'hDEADBEEF_01234567);
    rd("ram_13_mis", 64'h13, 64'hDEADBEEF_01234567);
    rd("ram_18", 64'h18, 64'h1);

    // Read during write to the same word: old value before the edge, new after
    @(negedge clk);
    direccion = 64'h18;
    dataWrite = 64'h2;
    memWr     = 1'b1;
    exp_q.push_back(64'h1);
    #1;
    chk("rdw_old", dataRead);
    @(posedge clk);
    exp_q.push_back(64'h2);
    #1;
    chk("rdw_new", dataRead);
    memWr = 1'b0;

    // Misaligned store lands in the containing word
    wr(64'h1F, 64'h3);
    rd("ram_1f_wr", 64'h18, 64'h3);

    // Last RAM word and first address past the RAM window
    wr(64'hF8, 64'hCAFE_F00D_1234_5678);
    rd("ram_last", 64'hF8, 64'hCAFE_F00D_1234_5678);
    wr(64'h100, 64'hBAD);
    rd("past_ram", 64'h100, 64'h0);
    rd("no_alias_0", 64'h0, 64'h0);

    // Switch port
    @(negedge clk);
    sw = 8'hC3;
`ifdef DMIO_SW_SYNC_EN
    rd("sw_sync_0", 64'h1008, 64'h0);
    @(posedge clk);
    #1;
    rd("sw_sync_1", 64'h1008, 64'h0);
    @(posedge clk);
    #1;
`endif
    rd("sw_c3", 64'h1008, 64'hC3);
    wr(64'h1008, 64'h77);
    led("sw_wr_led", 8'h5A);
    rd("sw_wr_ram10", 64'h10, 64'hDEADBEEF_01234567);
    rd("sw_wr_ram18", 64'h18, 64'h3);
    rd("sw_wr_rd", 64'h1008, 64'hC3);

    // Unmapped store
    wr(64'h2000, 64'h55);
    rd("unmap_rd", 64'h2000, 64'h0);
    led("unmap_led", 8'h5A);
    rd("unmap_ram10", 64'h10, 64'hDEADBEEF_01234567);

    // Store with memWr low has no effect
    @(negedge clk);
    direccion = 64'h1000;
    dataWrite = 64'h11;
    memWr     = 1'b0;
    @(posedge clk);
    led("nowr_led", 8'h5A);

    // Async reset mid-cycle
    wr(64'h1000, 64'h99);
    led("led_99", 8'h99);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    led("arst_led", 8'h00);
    rd("arst_ram10", 64'h10, 64'h0);
    rd("arst_ramf8", 64'hF8, 64'h0);

    // Stores during reset are dropped
    wr(64'h1000, 64'h42);
    led("rst_wr_led", 8'h00);

    // First store after mid-cycle release takes effect
    @(negedge clk);
    rst_n = 1'b1;
    wr(64'h1000, 64'h24);
    led("post_rst_led", 8'h24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
